// File: rtl/panel_pkg.sv
// Shared types for the push-button input panel: key count and the event record
// carried through the event FIFO.
package panel_pkg;

    localparam int NKEYS = 4;

    typedef struct packed {
        logic       press;
        logic [1:0] key;
    } key_event_t;

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: two-flop synchroniser, polarity invert, hold-time
// debounce counter, debounced level and a pending-event flag.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    input  logic inv,
    input  logic pending_clr,
    output logic state,
    output logic pending
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;
    logic          pending_q, pending_d;
    logic          sync_raw;

    // INV is quasi-static, so it is applied after the synchroniser rather than through it.
    assign sync_raw = ~(sync_q[1] ^ inv);

    always_comb begin
        sync_d    = {sync_q[0], key_n};
        cnt_d     = '0;
        state_d   = state_q;
        pending_d = pending_clr ? 1'b0 : pending_q;
        if (sync_raw != state_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                state_d   = sync_raw;
                pending_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            state_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    assign state   = state_q;
    assign pending = pending_q;

endmodule

// File: rtl/key_event_encoder.sv
// Debounces four active-low push-buttons and turns each accepted level change
// into a press/release event delivered through a fall-through FIFO (valid/ready).
module key_event_encoder
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic             CLOCK_50,
    input  logic             RST,
    input  logic [NKEYS-1:0] KEY,
    input  logic             INV,
    output logic             EV_VALID,
    input  logic             EV_READY,
    output logic             EV_PRESS,
    output logic [1:0]       EV_KEY,
    output logic [NKEYS-1:0] KEY_STATE,
    output logic             OVERFLOW
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NKEYS-1:0] pending, pending_clr;
    logic             push_q, push_d;
    key_event_t       push_ev_q, push_ev_d;
    key_event_t       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             pop, full, wr_en;
    logic [1:0]       sel_idx;
    key_event_t       head;

    for (genvar g = 0; g < NKEYS; g++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk        (CLOCK_50),
            .rst        (RST),
            .key_n      (KEY[g]),
            .inv        (INV),
            .pending_clr(pending_clr[g]),
            .state      (KEY_STATE[g]),
            .pending    (pending[g])
        );
    end

    // Descending scan so the lowest pending index is the one left selected.
    always_comb begin
        push_d      = 1'b0;
        sel_idx     = '0;
        pending_clr = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                push_d  = 1'b1;
                sel_idx = 2'(i);
            end
        end
        if (push_d) pending_clr[sel_idx] = 1'b1;
        push_ev_d = '{press: KEY_STATE[sel_idx], key: sel_idx};
    end

    assign full  = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign pop   = EV_VALID && EV_READY;
    assign wr_en = push_q && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
        overflow_d = overflow_q || (push_q && full && !pop);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            push_q     <= 1'b0;
            push_ev_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            push_q     <= push_d;
            push_ev_q  <= push_ev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is not reset; the head is masked by EV_VALID so stale words never reach the outputs.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_ev_q;
    end

    assign head     = mem_q[rd_ptr_q];
    assign EV_VALID = (count_q != '0);
    assign EV_PRESS = EV_VALID & head.press;
    assign EV_KEY   = EV_VALID ? head.key : 2'b00;
    assign OVERFLOW = overflow_q;

endmodule
